// File: rtl/arm_pkg.sv
// Shared types and constants for the EXE/MEM pipeline boundary.
// Holds the status-flag layout, the pipeline entry record and the occupancy encoding.
package arm_pkg;

    localparam int ARM_DATA_W = 32;
    localparam int ARM_REG_W  = 4;

    // Bit positions inside the {Z,C,N,V} status nibble; SR_C is the ALU carry-in.
    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } status_t;

    typedef struct packed {
        logic [ARM_DATA_W-1:0] result;
        logic [ARM_DATA_W-1:0] store_val;
        logic [ARM_REG_W-1:0]  dest;
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
    } exe_mem_t;

    // Encoded so that bit 0 is the main-entry valid and bit 1 the skid-entry valid.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_FULL  = 2'b11
    } occ_t;

endpackage

// File: rtl/status_reg.sv
// Architectural {Z,C,N,V} status register with synchronous reset and load enable.
// Feeds the committed flags back to the ALU.
module status_reg
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    status_t r_q;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= status_t'(i_d);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/exe_mem_reg.sv
// EXE->MEM pipeline register built as a 2-entry skid buffer, plus the committed status register.
// in_ready comes straight from a flop, so MEM backpressure never reaches EXE combinationally.
module exe_mem_reg
    import arm_pkg::*;
#(
    parameter int DATA_W = ARM_DATA_W,
    parameter int REG_W  = ARM_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [3:0]        in_status,
    input  logic              in_s,
    input  logic [DATA_W-1:0] in_store_val,
    input  logic [REG_W-1:0]  in_dest,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_val,
    output logic [REG_W-1:0]  out_dest,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [3:0]        sr
);

    occ_t     r_state;
    exe_mem_t r_main;
    exe_mem_t r_skid;

    logic     w_main_valid;
    logic     w_skid_valid;
    logic     w_acc;
    logic     w_pop;
    exe_mem_t w_in;

    assign w_main_valid = r_state[0];
    assign w_skid_valid = r_state[1];

    assign in_ready  = !w_skid_valid;
    assign out_valid = w_main_valid;

    assign w_acc = in_valid & in_ready & !flush;
    assign w_pop = w_main_valid & out_ready;

    assign w_in = '{
        result:    in_alu_result,
        store_val: in_store_val,
        dest:      in_dest,
        wb_en:     in_wb_en,
        mem_r_en:  in_mem_r_en,
        mem_w_en:  in_mem_w_en
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: both entries are cleared, not just the valid bits, because out_* must read 0 after reset.
            r_state <= OCC_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= OCC_EMPTY;
        end else begin
            unique case (r_state)
                OCC_EMPTY: begin
                    if (w_acc) begin
                        r_main  <= w_in;
                        r_state <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_acc && w_pop) begin
                        r_main <= w_in;
                    end else if (w_acc) begin
                        r_skid  <= w_in;
                        r_state <= OCC_FULL;
                    end else if (w_pop) begin
                        r_state <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= OCC_ONE;
                    end
                end
                default: r_state <= OCC_EMPTY;
            endcase
        end
    end

    assign out_alu_result = r_main.result;
    assign out_store_val  = r_main.store_val;
    assign out_dest       = r_main.dest;
    assign out_wb_en      = r_main.wb_en;
    assign out_mem_r_en   = r_main.mem_r_en;
    assign out_mem_w_en   = r_main.mem_w_en;

    // Flags commit only with an accepted instruction, so a flushed input never touches sr.
    status_reg u_status_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_acc & in_s),
        .i_d    (in_status),
        .o_q    (sr)
    );

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed self-checking bench for exe_mem_reg: reset, latency, backpressure, streaming,
// flag gating, flush while full and reset while full.
module tb_exe_mem_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [3:0]  in_status;
    logic        in_s;
    logic [31:0] in_store_val;
    logic [3:0]  in_dest;
    logic        in_wb_en;
    logic        in_mem_r_en;
    logic        in_mem_w_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_val;
    logic [3:0]  out_dest;
    logic        out_wb_en;
    logic        out_mem_r_en;
    logic        out_mem_w_en;
    logic [3:0]  sr;

    int n_tests = 0;
    int n_fail  = 0;

    exe_mem_reg dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_result  (in_alu_result),
        .in_status      (in_status),
        .in_s           (in_s),
        .in_store_val   (in_store_val),
        .in_dest        (in_dest),
        .in_wb_en       (in_wb_en),
        .in_mem_r_en    (in_mem_r_en),
        .in_mem_w_en    (in_mem_w_en),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_store_val  (out_store_val),
        .out_dest       (out_dest),
        .out_wb_en      (out_wb_en),
        .out_mem_r_en   (out_mem_r_en),
        .out_mem_w_en   (out_mem_w_en),
        .sr             (sr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Side fields are derived from the result so each entry is uniquely tagged.
    function automatic logic [31:0] store_of(input logic [31:0] r);
        return r ^ 32'hA5A5_0000;
    endfunction

    task automatic drive(input logic v, input logic [31:0] r, input logic s, input logic [3:0] st);
        in_valid      = v;
        in_alu_result = r;
        in_s          = s;
        in_status     = st;
        in_store_val  = store_of(r);
        in_dest       = r[3:0];
        in_wb_en      = 1'b1;
        in_mem_r_en   = r[0];
        in_mem_w_en   = ~r[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_entry(input string tag, input logic [31:0] r);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_result"}, out_alu_result, r);
        chk({tag, "_store"}, out_store_val, store_of(r));
        chk({tag, "_dest"}, {28'b0, out_dest}, {28'b0, r[3:0]});
        chk({tag, "_ctrl"}, {29'b0, out_wb_en, out_mem_r_en, out_mem_w_en},
            {29'b0, 1'b1, r[0], ~r[0]});
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'b0000);

        // Reset state
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", out_alu_result, 32'd0);
        chk("rst_sr", {28'b0, sr}, 32'd0);
        rst = 1'b0;
        tick();

        // Single transfer: one-cycle latency, sr commits at the accept edge
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 1'b1, 4'b0100);
        tick();
        chk_entry("single", 32'h5);
        chk("single_sr", {28'b0, sr}, 32'h4);
        drive(1'b0, 32'h0, 1'b0, 4'b0000);
        tick();
        chk("single_drain", {31'b0, out_valid}, 32'd0);

        // Backpressure: A, B fill the buffer, C is held off
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 1'b0, 4'b0000);
        tick();
        chk("bp_a_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'd2, 1'b0, 4'b0000);
        tick();
        chk("bp_b_ready", {31'b0, in_ready}, 32'd0);
        chk_entry("bp_hold_a", 32'd1);
        drive(1'b1, 32'd3, 1'b0, 4'b0000);
        tick();
        chk("bp_c_blocked", {31'b0, in_ready}, 32'd0);
        chk_entry("bp_still_a", 32'd1);
        out_ready = 1'b1;
        tick();
        chk_entry("bp_out_b", 32'd2);
        chk("bp_ready_again", {31'b0, in_ready}, 32'd1);
        tick();
        chk_entry("bp_out_c", 32'd3);
        drive(1'b0, 32'h0, 1'b0, 4'b0000);
        tick();
        chk("bp_no_dup", {31'b0, out_valid}, 32'd0);

        // Streaming: one entry per cycle, in_ready never drops
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + i, 1'b0, 4'b0000);
            chk($sformatf("stream_ready_%0d", i), {31'b0, in_ready}, 32'd1);
            tick();
            chk($sformatf("stream_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stream_data_%0d", i), out_alu_result, 32'h10 + i);
        end
        drive(1'b0, 32'h0, 1'b0, 4'b0000);
        tick();
        chk("stream_drain", {31'b0, out_valid}, 32'd0);

        // Flag gating: in_s=0 must not commit flags
        drive(1'b1, 32'h20, 1'b1, 4'b0010);
        tick();
        chk("gate_set_sr", {28'b0, sr}, 32'h2);
        drive(1'b1, 32'h21, 1'b0, 4'b1111);
        tick();
        chk("gate_hold_sr", {28'b0, sr}, 32'h2);
        chk_entry("gate_entry", 32'h21);
        drive(1'b0, 32'h0, 1'b0, 4'b0000);
        tick();

        // Flush while FULL with a flag-setting input in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 32'h31, 1'b0, 4'b0000);
        tick();
        chk("fl_full", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h32, 1'b1, 4'b1000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'b0000);
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
        chk("fl_sr", {28'b0, sr}, 32'h2);
        tick();
        chk("fl_stays_empty", {31'b0, out_valid}, 32'd0);

        // Flush with a concurrent input while ONE: input discarded, sr untouched
        out_ready = 1'b0;
        drive(1'b1, 32'h40, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 32'h41, 1'b1, 4'b0001);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'b0000);
        chk("fl1_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl1_sr", {28'b0, sr}, 32'h2);

        // Reset while FULL
        drive(1'b1, 32'h7, 1'b1, 4'b0101);
        tick();
        chk("rf_sr", {28'b0, sr}, 32'h5);
        drive(1'b1, 32'h8, 1'b0, 4'b0000);
        tick();
        chk("rf_full", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h9, 1'b1, 4'b1111);
        rst       = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'b0000);
        chk("rf_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rf_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rf_result", out_alu_result, 32'd0);
        chk("rf_store", out_store_val, 32'd0);
        chk("rf_dest", {28'b0, out_dest}, 32'd0);
        chk("rf_ctrl", {29'b0, out_wb_en, out_mem_r_en, out_mem_w_en}, 32'd0);
        chk("rf_sr0", {28'b0, sr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
